// File: rtl/apb_pkg.sv
// Shared types and decode helpers for the APB register file.
package apb_pkg;

    localparam int MAX_REGS = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [31:0] idx;
        logic        err;
    } apb_dec_t;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    // Index is addr/bytes; error on misalignment, out-of-range index or a write to a read-only register.
    function automatic apb_dec_t apb_decode(input logic [63:0]         addr,
                                            input logic                wr,
                                            input int unsigned         bytes,
                                            input int unsigned         num_regs,
                                            input logic [MAX_REGS-1:0] ro_mask);
        apb_dec_t    d;
        logic [63:0] idx64;
        idx64 = addr / 64'(bytes);
        d.idx = idx64[31:0];
        if ((addr % 64'(bytes)) != 64'd0) begin
            d.err = 1'b1;
        end else if (idx64 >= 64'(num_regs)) begin
            d.err = 1'b1;
        end else if (wr && ro_mask[idx64[9:0]]) begin
            d.err = 1'b1;
        end else begin
            d.err = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/apb_regfile_if.sv
// APB4 completer-side bus bundle for the register file.
interface apb_regfile_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic                  pready;
    logic [DATA_W-1:0]     prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_regfile_reg.sv
// One register with byte-strobe write merge and asynchronous clear.
module apb_regfile_reg
    import apb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [strb_w(DATA_W)-1:0]  strb,
    output logic [DATA_W-1:0]          q
);
    localparam int BYTES = strb_w(DATA_W);

    logic [DATA_W-1:0] q_r;
    logic [DATA_W-1:0] merged_s;

    // Select new or old byte lane by strobe.
    always_comb begin
        merged_s = q_r;
        for (int k = 0; k < BYTES; k++) begin
            if (strb[k]) begin
                merged_s[k*8 +: 8] = wdata[k*8 +: 8];
            end else begin
                merged_s[k*8 +: 8] = q_r[k*8 +: 8];
            end
        end
    end

    // Register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
        end else if (we) begin
            q_r <= merged_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;
endmodule

// File: rtl/apb_regfile.sv
// APB4 completer register file: FSM with optional wait states, decode, read mux and write pulses.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 32,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    apb_regfile_if.slave                 bus,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_pulse
);
    localparam int          BYTES     = strb_w(DATA_W);
    localparam logic [1:0]  S_IDLE    = ST_IDLE;
    localparam logic [1:0]  S_WAIT    = ST_WAIT;
    localparam logic [1:0]  S_DONE    = ST_DONE;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]          state_r, state_nxt_s;
    logic [3:0]          cnt_r;
    logic                pready_r;
    logic [NUM_REGS-1:0] wr_pulse_r;
    logic [NUM_REGS-1:0] we_s;
    logic                wr_en_s;
    logic [DATA_W-1:0]   rd_s;
    logic [DATA_W-1:0]   regs_s [NUM_REGS];
    apb_dec_t            dec_s;

    assign dec_s = apb_decode(64'(bus.paddr), bus.pwrite, BYTES, NUM_REGS, MAX_REGS'(RO_MASK));

    // Next-state logic; dropping psel outside IDLE abandons the transfer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_nxt_s = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!bus.psel) begin
                    state_nxt_s = S_IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, wait counter and pready (registered, so no path from penable).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= 4'd0;
            pready_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pready_r <= (state_nxt_s == S_DONE);
            if (state_r == S_IDLE && state_nxt_s == S_WAIT) begin
                cnt_r <= WAIT_LOAD;
            end else if (state_r == S_WAIT && cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign wr_en_s = (state_r == S_DONE) && bus.psel && bus.penable && bus.pwrite && !dec_s.err;

    // Per-register write enables and read mux.
    always_comb begin
        we_s = '0;
        rd_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dec_s.idx == 32'(i)) begin
                we_s[i] = wr_en_s && !RO_MASK[i];
                rd_s    = regs_s[i];
            end else begin
                we_s[i] = 1'b0;
            end
        end
    end

    // Write pulse lines up with the updated register value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pulse_r <= '0;
        end else begin
            wr_pulse_r <= we_s;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        apb_regfile_reg #(.DATA_W(DATA_W)) u_reg (
            .clk   (clk),
            .rst   (rst),
            .we    (we_s[g]),
            .wdata (bus.pwdata),
            .strb  (bus.pstrb),
            .q     (regs_s[g])
        );
        assign reg_q[g*DATA_W +: DATA_W] = regs_s[g];
    end

    assign bus.pready  = pready_r;
    assign bus.pslverr = (state_r == S_DONE) && dec_s.err;
    assign bus.prdata  = ((state_r == S_DONE) && !bus.pwrite && !dec_s.err) ? rd_s : '0;
    assign wr_pulse    = wr_pulse_r;
endmodule

// File: tb/tb_apb_regfile.sv
// Randomized self-checking bench for apb_regfile with zero and three wait states.
module tb_apb_regfile;
    localparam logic [15:0] RO = 16'h8010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        psel_v = 1'b0, penable_v = 1'b0, pwrite_v = 1'b0;
    logic [31:0] paddr_v = 32'd0, pwdata_v = 32'd0;
    logic [3:0]  pstrb_v = 4'd0;
    int          cur = 0;

    apb_regfile_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    apb_regfile_if #(.ADDR_W(32), .DATA_W(32)) if3 ();
    logic [511:0] rq0, rq3;
    logic [15:0]  wp0, wp3;

    assign if0.psel = psel_v && (cur == 0);
    assign if3.psel = psel_v && (cur == 1);
    assign if0.penable = penable_v; assign if3.penable = penable_v;
    assign if0.pwrite  = pwrite_v;  assign if3.pwrite  = pwrite_v;
    assign if0.paddr   = paddr_v;   assign if3.paddr   = paddr_v;
    assign if0.pwdata  = pwdata_v;  assign if3.pwdata  = pwdata_v;
    assign if0.pstrb   = pstrb_v;   assign if3.pstrb   = pstrb_v;

    apb_regfile #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(16), .WAIT_CYCLES(0), .RO_MASK(RO)) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .reg_q(rq0), .wr_pulse(wp0));
    apb_regfile #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(16), .WAIT_CYCLES(3), .RO_MASK(RO)) dut3 (
        .clk(clk), .rst(rst), .bus(if3), .reg_q(rq3), .wr_pulse(wp3));

    logic         pready_w, pslverr_w;
    logic [31:0]  prdata_w;
    logic [511:0] reg_q_w;
    logic [15:0]  wr_pulse_w;
    assign pready_w   = cur ? if3.pready  : if0.pready;
    assign pslverr_w  = cur ? if3.pslverr : if0.pslverr;
    assign prdata_w   = cur ? if3.prdata  : if0.prdata;
    assign reg_q_w    = cur ? rq3 : rq0;
    assign wr_pulse_w = cur ? wp3 : wp0;

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] model [2][16];
    logic [15:0] setup_pulse;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] flat(input int d);
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = model[d][i];
        return f;
    endfunction

    // Reference behaviour: index, error rules and strobe merge straight from the register map.
    task automatic model_op(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic exp_err, output logic [31:0] exp_rd,
                            output logic [15:0] exp_pulse);
        int unsigned idx;
        idx = addr / 4;
        exp_rd = 32'd0;
        exp_pulse = 16'd0;
        if (addr % 4 != 0)         exp_err = 1'b1;
        else if (idx >= 16)        exp_err = 1'b1;
        else if (wr && RO[idx])    exp_err = 1'b1;
        else                       exp_err = 1'b0;
        if (!exp_err) begin
            if (wr) begin
                for (int k = 0; k < 4; k++)
                    if (strb[k]) model[d][idx][k*8 +: 8] = data[k*8 +: 8];
                exp_pulse = 16'd1 << idx;
            end else begin
                exp_rd = model[d][idx];
            end
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err, output int waits);
        @(negedge clk);
        psel_v = 1'b1; penable_v = 1'b0; pwrite_v = wr;
        paddr_v = addr; pwdata_v = data; pstrb_v = strb;
        #1 setup_pulse = wr_pulse_w;
        @(negedge clk);
        penable_v = 1'b1;
        waits = 0;
        #1;
        while (!pready_w && waits < 40) begin
            @(negedge clk); #1;
            waits++;
        end
        if (!pready_w) check_val("pready_timeout", 512'(pready_w), 512'd1);
        rdata = prdata_w;
        err   = pslverr_w;
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        psel_v = 1'b0; penable_v = 1'b0;
    endtask

    // Model-predicted transfer with all response checks.
    task automatic do_op(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         output logic [15:0] exp_pulse);
        logic [31:0] rd, exp_rd;
        logic        er, exp_err;
        int          w;
        model_op(cur, wr, addr, data, strb, exp_err, exp_rd, exp_pulse);
        xfer(wr, addr, data, strb, rd, er, w);
        check_val("prdata", 512'(rd), 512'(exp_rd));
        check_val("pslverr", 512'(er), 512'(exp_err));
        check_val("wait_count", 512'(w), 512'((cur == 1) ? 3 : 0));
    endtask

    logic [15:0] pl;
    logic [31:0] rd;
    logic        er;
    int          w;

    initial begin
        for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) model[d][i] = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_pready", 512'({if0.pready, if3.pready}), 512'd0);
        check_val("rst_pslverr", 512'({if0.pslverr, if3.pslverr}), 512'd0);
        check_val("rst_prdata", 512'({if0.prdata, if3.prdata}), 512'd0);
        check_val("rst_wr_pulse", 512'({wp0, wp3}), 512'd0);
        check_val("rst_reg_q0", rq0, 512'd0);
        check_val("rst_reg_q3", rq3, 512'd0);

        // Zero wait states: directed cases.
        cur = 0;
        do_op(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, pl);
        idle_cyc(); #1 check_val("wr_pulse_2", 512'(wr_pulse_w), 512'(16'h0004));
        idle_cyc(); #1 check_val("wr_pulse_clear", 512'(wr_pulse_w), 512'd0);
        xfer(1'b0, 32'h8, 32'd0, 4'h0, rd, er, w);
        check_val("read_deadbeef", 512'(rd), 512'(32'hDEADBEEF));
        model[0][2] = 32'hDEADBEEF;
        idle_cyc();
        do_op(1'b1, 32'h8, 32'h11223344, 4'h5, pl);
        idle_cyc(); #1 check_val("strb_merge", 512'(reg_q_w[2*32 +: 32]), 512'(32'hDE22BE44));
        do_op(1'b0, 32'h40, 32'd0, 4'h0, pl);
        do_op(1'b0, 32'h6, 32'd0, 4'h0, pl);
        do_op(1'b1, 32'h10, 32'h55, 4'hF, pl);
        idle_cyc(); #1 check_val("err_no_change", reg_q_w, flat(0));
        do_op(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, pl);
        do_op(1'b1, 32'h4, 32'h5A5A5A5A, 4'hF, pl);
        check_val("b2b_pulse0", 512'(setup_pulse), 512'(16'h0001));
        idle_cyc(); #1 check_val("b2b_pulse1", 512'(wr_pulse_w), 512'(16'h0002));
        check_val("b2b_regs", reg_q_w, flat(0));

        // Three wait states.
        cur = 1;
        do_op(1'b1, 32'h4, 32'h12345678, 4'hF, pl);
        idle_cyc();
        do_op(1'b0, 32'h4, 32'd0, 4'h0, pl);
        idle_cyc();

        // psel dropped during the wait phase.
        @(negedge clk);
        psel_v = 1'b1; penable_v = 1'b0; pwrite_v = 1'b1; paddr_v = 32'h0; pwdata_v = 32'hFFFFFFFF; pstrb_v = 4'hF;
        @(negedge clk); penable_v = 1'b1;
        #1 check_val("abort_pready_a", 512'(pready_w), 512'd0);
        @(negedge clk); psel_v = 1'b0; penable_v = 1'b0;
        #1 check_val("abort_pready_b", 512'(pready_w), 512'd0);
        @(negedge clk);
        #1 check_val("abort_pready_c", 512'(pready_w), 512'd0);
        check_val("abort_regs", reg_q_w, flat(1));
        check_val("abort_pulse", 512'(wr_pulse_w), 512'd0);

        // Reset during a write access.
        @(negedge clk);
        psel_v = 1'b1; penable_v = 1'b0; pwrite_v = 1'b1; paddr_v = 32'h8; pwdata_v = 32'hCAFEF00D; pstrb_v = 4'hF;
        @(negedge clk); penable_v = 1'b1;
        @(negedge clk); rst = 1'b1;
        #1 check_val("rst_mid_regs3", rq3, 512'd0);
        check_val("rst_mid_regs0", rq0, 512'd0);
        @(negedge clk); rst = 1'b0; psel_v = 1'b0; penable_v = 1'b0;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) model[d][i] = 32'd0;
        for (int d = 0; d < 2; d++) begin
            cur = d;
            do_op(1'b0, 32'h4, 32'd0, 4'h0, pl);
            do_op(1'b0, 32'h8, 32'd0, 4'h0, pl);
            idle_cyc();
        end

        // Randomized traffic against the reference model.
        for (int d = 0; d < 2; d++) begin
            cur = d;
            for (int n = 0; n < 150; n++) begin
                logic [31:0] a;
                a = 32'($urandom_range(0, 17)) * 32'd4;
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
                do_op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), pl);
                if ($urandom_range(0, 1) == 1) begin
                    idle_cyc(); #1;
                    check_val("rand_pulse", 512'(wr_pulse_w), 512'(pl));
                    check_val("rand_regs", reg_q_w, flat(d));
                end
            end
            idle_cyc(); #1;
            check_val("rand_final_regs", reg_q_w, flat(d));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
